prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter WIDTH, default 32: data/address width matching the processor.
REQ-002 Parameter MEM_DEPTH, default 16384: byte capacity of processor main memory.
REQ-003 Parameter BASE_ADDR, default 0: first byte address written.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  reset is asynchronous and active-low.
REQ-006 start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
REQ-007 in_valid  input  1  input word present.
REQ-008 in_data  input  WIDTH  program word, little-endian byte order.
REQ-009 in_last  input  1  marks final beat of image.
REQ-010 in_ready  output  1  loader accepts a word this cycle.
REQ-011 memEn  output  1  byte-write strobe to processor memory port.
REQ-012 memAddr  output  WIDTH  byte address of current write.
REQ-013 memData  output  WIDTH  write byte in [7:0], upper bits zero.
REQ-014 cpuReset  output  1  active-high synchronous reset to processor.
REQ-015 done  output  1  image loaded; processor released.
REQ-016 err_overflow  output  1  image exceeded MEM_DEPTH.
REQ-017 err_checksum  output  1  checksum mismatch (see Configuration).
REQ-018 word_count  output  WIDTH  words written since last start.

Function
REQ-019 FSM states IDLE, ACCEPT, WRITE, DONE, ERROR; all outputs registered.
REQ-020 IDLE: in_ready=0, memEn=0, cpuReset=1; start -> ACCEPT, address register = BASE_ADDR, word_count=0, errors cleared.
REQ-021 ACCEPT: in_ready=1; transfer only on in_valid & in_ready; word and in_last captured; -> WRITE.
REQ-022 Overflow: if accepted word needs address+4 > MEM_DEPTH, no byte written -> ERROR, err_overflow=1.
REQ-023 WRITE: four consecutive cycles memEn=1, bytes [7:0],[15:8],[23:16],[31:24] at address, +1, +2, +3; in_ready=0.
REQ-024 Latency: word accepted at edge N drives memEn high for the cycles following edges N+1..N+4; throughput one word per 5 cycles.
REQ-025 After 4th byte: address += 4, word_count += 1; in_last -> DONE else -> ACCEPT.
REQ-026 DONE: cpuReset=0, done=1, memEn=0, in_ready=0; start -> ACCEPT with cpuReset=1 and done=0 from next cycle.
REQ-027 ERROR: cpuReset=1, memEn=0, in_ready=0; error flag held until start.
REQ-028 start while in ACCEPT or WRITE is ignored; in_valid outside ACCEPT is ignored.
REQ-029 Address arithmetic is WIDTH-bit unsigned; BASE_ADDR not word-aligned is legal.

Reset
REQ-030 reset_n low forces immediately IDLE, memEn=0, in_ready=0, cpuReset=1, done=0, errors=0, memAddr=0, memData=0, word_count=0.
REQ-031 Reset mid-WRITE abandons the word; no further bytes are written after release.

Configuration
REQ-032 Macro PROG_LOADER_CHECKSUM_EN defined: in_last beat is a checksum word, not written; it is compared to the mod-2^32 sum of all written words; match -> DONE, mismatch -> ERROR with err_checksum=1.
REQ-033 Macro undefined: in_last beat is written as a program word; err_checksum tied 0; no accumulator is present.

Structure
REQ-034 Package prog_loader_pkg holds the state enum typedef and the constant BYTES_PER_WORD=4.
REQ-035 One sub-module, prog_loader_serializer: a word-to-byte shift register with a 2-bit byte counter, driving memData/memEn.

Verification
REQ-036 Reset, start, 2 words 0x00000013, 0x00100093 (last) -> bytes 13,00,00,00,93,00,10,00 at addresses 0..7; then done=1, cpuReset=0, word_count=2.
REQ-037 in_valid held low 10 cycles in ACCEPT -> memEn stays 0, state unchanged; word 0xDEADBEEF then written as EF,BE,AD,DE.
REQ-038 MEM_DEPTH=8, three words -> first two written, third not; err_overflow=1, cpuReset=1.
REQ-039 reset_n low during 2nd byte of a word -> memEn=0 immediately; after release no writes until start.
REQ-040 With PROG_LOADER_CHECKSUM_EN: words 1, 2, checksum 3 -> done=1; checksum 4 -> err_checksum=1, cpuReset=1.
REQ-041 From DONE, start pulse -> cpuReset=1 next cycle, reload at BASE_ADDR, word_count restarts at 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Image stream in, byte-write memory port out; master is the host/memory side, slave is the loader.
interface prog_loader_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             memEn;
    logic [WIDTH-1:0] memAddr;
    logic [WIDTH-1:0] memData;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, memEn, memAddr, memData
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, memEn, memAddr, memData
    );
endinterface

// File: rtl/prog_loader_serializer.sv
// Word-to-byte shifter: one load emits four registered byte writes, LSB first, at consecutive addresses.
module prog_loader_serializer
    import prog_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] addr,
    output logic             last_byte,
    output logic             mem_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data
);

    logic             busy;
    logic [1:0]       byte_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] addr_q;

    // High in the cycle whose edge emits the final byte, so the FSM can leave WRITE on that edge.
    assign last_byte = busy && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            byte_cnt <= 2'd0;
            shreg    <= '0;
            addr_q   <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_en <= busy;
            if (load) begin
                shreg    <= word;
                addr_q   <= addr;
                byte_cnt <= 2'd0;
                busy     <= 1'b1;
            end else if (busy) begin
                mem_addr <= addr_q;
                mem_data <= {{(WIDTH-8){1'b0}}, shreg[7:0]};
                shreg    <= shreg >> 8;
                addr_q   <= addr_q + WIDTH'(1);
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a streamed program image into processor memory byte by byte, holding the CPU in reset until done.
// Define PROG_LOADER_CHECKSUM_EN to treat the final beat as a checksum of the written words.
//
// state  | meaning
// IDLE   | after reset, CPU held, waiting for start
// ACCEPT | ready for the next image word
// WRITE  | serializer emitting the four bytes of the captured word
// DONE   | image loaded, CPU released
// ERROR  | overflow or checksum failure, CPU held until start
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MEM_DEPTH = 16384,
    parameter int BASE_ADDR = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    prog_loader_if.slave     bus,
    output logic             cpuReset,
    output logic             done,
    output logic             err_overflow,
    output logic             err_checksum,
    output logic [WIDTH-1:0] word_count
);

    state_t           state, next_state;
    logic [WIDTH-1:0] addr;
    logic             last_q;
    logic             load, clr, word_done, ovf_set;
    logic             ser_last;
    logic             accept;
    logic             no_room;

    assign accept  = bus.in_valid && bus.in_ready;
    // One extra bit keeps addr+4 from wrapping before the depth compare.
    assign no_room = ({1'b0, addr} + (WIDTH+1)'(BYTES_PER_WORD)) > (WIDTH+1)'(MEM_DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum;
    logic             cks_set;
`endif

    always_comb begin
        next_state = state;
        load       = 1'b0;
        clr        = 1'b0;
        word_done  = 1'b0;
        ovf_set    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        cks_set    = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    next_state = ST_ACCEPT;
                    clr        = 1'b1;
                end
            end
            ST_ACCEPT: begin
                if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (bus.in_last) begin
                        if (bus.in_data == sum) begin
                            next_state = ST_DONE;
                        end else begin
                            next_state = ST_ERROR;
                            cks_set    = 1'b1;
                        end
                    end else
`endif
                    if (no_room) begin
                        next_state = ST_ERROR;
                        ovf_set    = 1'b1;
                    end else begin
                        next_state = ST_WRITE;
                        load       = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (ser_last) begin
                    word_done  = 1'b1;
                    next_state = last_q ? ST_DONE : ST_ACCEPT;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Release waits one cycle in DONE so the last byte lands before the CPU runs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bus.in_ready <= 1'b0;
            cpuReset     <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            addr         <= WIDTH'(BASE_ADDR);
            word_count   <= '0;
            last_q       <= 1'b0;
        end else begin
            state        <= next_state;
            bus.in_ready <= (next_state == ST_ACCEPT);
            done         <= (state == ST_DONE) && (next_state == ST_DONE);
            cpuReset     <= !((state == ST_DONE) && (next_state == ST_DONE));
            if (clr) begin
                addr         <= WIDTH'(BASE_ADDR);
                word_count   <= '0;
                err_overflow <= 1'b0;
            end
            if (load) begin
                last_q <= bus.in_last;
            end
            if (word_done) begin
                addr       <= addr + WIDTH'(BYTES_PER_WORD);
                word_count <= word_count + WIDTH'(1);
            end
            if (ovf_set) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum          <= '0;
            err_checksum <= 1'b0;
        end else begin
            if (clr) begin
                sum          <= '0;
                err_checksum <= 1'b0;
            end
            if (load) begin
                sum <= sum + bus.in_data;
            end
            if (cks_set) begin
                err_checksum <= 1'b1;
            end
        end
    end
`else
    assign err_checksum = 1'b0;
`endif

    prog_loader_serializer #(
        .WIDTH (WIDTH)
    ) u_serializer (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .word      (bus.in_data),
        .addr      (addr),
        .last_byte (ser_last),
        .mem_en    (bus.memEn),
        .mem_addr  (bus.memAddr),
        .mem_data  (bus.memData)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: model pushes expected byte writes, a negedge monitor pops them.
module tb_prog_loader;

    localparam int WIDTH     = 32;
    localparam int MEM_DEPTH = 64;
    localparam int BASE_ADDR = 0;

    localparam int OUT_NONE = 0;
    localparam int OUT_DONE = 1;
    localparam int OUT_OVF  = 2;
    localparam int OUT_CKS  = 3;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             cpuReset;
    logic             done;
    logic             err_overflow;
    logic             err_checksum;
    logic [WIDTH-1:0] word_count;

    prog_loader_if #(.WIDTH(WIDTH)) bus ();

    prog_loader #(
        .WIDTH     (WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .bus          (bus),
        .cpuReset     (cpuReset),
        .done         (done),
        .err_overflow (err_overflow),
        .err_checksum (err_checksum),
        .word_count   (word_count)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    wr_t         exp_q[$];
    logic [31:0] words[0:31];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every byte write must match the head of the expected queue, on time.
    always @(negedge clock) begin
        wr_t e;
        if (reset_n) begin
            if (bus.memEn) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: addr=0x%0h data=0x%0h cyc=%0d", bus.memAddr, bus.memData, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.memAddr === e.addr && bus.memData === {24'h0, e.data} && cyc == e.cyc)
                        n_pass++;
                    else
                        $display("FAIL write: got addr=0x%0h data=0x%0h cyc=%0d expected addr=0x%0h data=0x%0h cyc=%0d",
                                 bus.memAddr, bus.memData, cyc, e.addr, e.data, e.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                n_total++;
                e = exp_q.pop_front();
                $display("FAIL missing_write: got memEn=0 expected addr=0x%0h data=0x%0h at cyc=%0d", e.addr, e.data, e.cyc);
            end
        end
    end

    task automatic push_word(input logic [31:0] a, input logic [31:0] d, input int p);
        for (int k = 0; k < 4; k++) begin
            wr_t e;
            e.addr = 32'(a + 32'(k));
            e.data = d[8*k +: 8];
            e.cyc  = p + 2 + k;
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns the cycle count seen when the accepting edge was still ahead.
    task automatic send_beat(input logic [31:0] d, input logic l, output int acc_cyc, output bit ok);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        ok = 1'b0;
        acc_cyc = 0;
        for (int t = 0; t < 100; t++) begin
            if (bus.in_ready) begin
                acc_cyc = cyc;
                @(negedge clock);
                bus.in_valid = 1'b0;
                ok = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_in_ready", {31'h0, bus.in_ready}, 32'd1);
        chk("start_cpu_reset", {31'h0, cpuReset}, 32'd1);
        chk("start_done", {31'h0, done}, 32'd0);
        chk("start_word_count", word_count, 32'd0);
        chk("start_err_overflow", {31'h0, err_overflow}, 32'd0);
    endtask

    task automatic run_session(input int n, input bit bad_cks, input int pre_idle);
        int          nb;
        int          p;
        int          outcome;
        int          m_count;
        longint      m_addr;
        logic [31:0] m_sum;
        logic [31:0] beat;
        bit          ok;
        bit          stop;
        bit          is_cks;
        do_start();
        repeat (pre_idle) @(negedge clock);
        if (pre_idle > 0) chk("accept_hold_ready", {31'h0, bus.in_ready}, 32'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
        nb = n + 1;
`else
        nb = n;
`endif
        m_addr = BASE_ADDR; m_count = 0; m_sum = 0; outcome = OUT_NONE; stop = 1'b0;
        for (int i = 0; i < nb && !stop; i++) begin
            // Idle gaps with stray start pulses, which must be ignored mid-load.
            repeat ($urandom_range(0, 3)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
                start = ($urandom_range(0, 5) == 0);
                @(negedge clock);
                start = 1'b0;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            is_cks = (i == n);
`else
            is_cks = 1'b0;
`endif
            beat = is_cks ? (bad_cks ? m_sum + 32'd1 : m_sum) : words[i];
            send_beat(beat, (i == nb - 1), p, ok);
            if (!ok) begin
                chk("accept_timeout", 32'd0, 32'd1);
                stop = 1'b1;
            end else if (is_cks) begin
                outcome = (beat == m_sum) ? OUT_DONE : OUT_CKS;
                stop = 1'b1;
            end else if (m_addr + 4 > MEM_DEPTH) begin
                outcome = OUT_OVF;
                stop = 1'b1;
            end else begin
                push_word(32'(m_addr), beat, p);
                m_addr  += 4;
                m_count += 1;
                m_sum   += beat;
                if (i == nb - 1) begin
                    outcome = OUT_DONE;
                    stop = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 60 && !(done || err_overflow || err_checksum); t++) @(negedge clock);
        chk("finish_seen", {31'h0, (done || err_overflow || err_checksum)}, 32'd1);
        repeat (3) @(negedge clock);
        chk("end_done", {31'h0, done}, {31'h0, outcome == OUT_DONE});
        chk("end_cpu_reset", {31'h0, cpuReset}, {31'h0, outcome != OUT_DONE});
        chk("end_err_overflow", {31'h0, err_overflow}, {31'h0, outcome == OUT_OVF});
        chk("end_err_checksum", {31'h0, err_checksum}, {31'h0, outcome == OUT_CKS});
        chk("end_word_count", word_count, 32'(m_count));
        chk("end_in_ready", {31'h0, bus.in_ready}, 32'd0);
        chk("end_pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_test();
        int p;
        bit ok;
        do_start();
        send_beat(32'hA5A5_1234, 1'b0, p, ok);
        chk("rst_accept0", {31'h0, ok}, 32'd1);
        push_word(32'(BASE_ADDR), 32'hA5A5_1234, p);
        send_beat(32'h0BAD_F00D, 1'b0, p, ok);
        chk("rst_accept1", {31'h0, ok}, 32'd1);
        push_word(32'(BASE_ADDR + 4), 32'h0BAD_F00D, p);
        while (cyc < p + 3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mem_en", {31'h0, bus.memEn}, 32'd0);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
        chk("rst_cpu_reset", {31'h0, cpuReset}, 32'd1);
        chk("rst_word_count", word_count, 32'd0);
        chk("rst_mem_addr", bus.memAddr, 32'd0);
        chk("rst_mem_data", bus.memData, 32'd0);
        exp_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1111_2222;
        bus.in_last  = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("post_rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
        chk("post_rst_cpu_reset", {31'h0, cpuReset}, 32'd1);
        chk("post_rst_done", {31'h0, done}, 32'd0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_in_ready", {31'h0, bus.in_ready}, 32'd0);
        chk("reset_mem_en", {31'h0, bus.memEn}, 32'd0);
        chk("reset_cpu_reset", {31'h0, cpuReset}, 32'd1);
        chk("reset_done", {31'h0, done}, 32'd0);
        chk("reset_err_overflow", {31'h0, err_overflow}, 32'd0);
        chk("reset_err_checksum", {31'h0, err_checksum}, 32'd0);
        chk("reset_mem_addr", bus.memAddr, 32'd0);
        chk("reset_mem_data", bus.memData, 32'd0);
        chk("reset_word_count", word_count, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_cpu_reset", {31'h0, cpuReset}, 32'd1);

        words[0] = 32'h0000_0013; words[1] = 32'h0010_0093;
        run_session(2, 1'b0, 0);
        words[0] = 32'hDEAD_BEEF;
        run_session(1, 1'b0, 10);
        for (int i = 0; i < 17; i++) words[i] = $urandom;
        run_session(MEM_DEPTH / 4, 1'b0, 0);
        run_session(MEM_DEPTH / 4 + 1, 1'b0, 0);
        words[0] = 32'd1; words[1] = 32'd2;
        run_session(2, 1'b0, 0);
        run_session(2, 1'b1, 0);
        reset_test();
        repeat (30) begin
            int n;
            n = $urandom_range(1, 18);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            run_session(n, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        words[0] = 32'hCAFE_0001;
        run_session(1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
